dsp_dotprod_seq: RTL and testbench
==================================

Name: dsp_dotprod_seq

Overview:
- Sequencer that drives one DSP48A1 slice as a multiply-accumulate engine for dot-product jobs.
- The slice is configured with A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1 and B_INPUT="DIRECT".
- The block accepts a job (length, add/subtract), streams operand pairs into the slice over a valid/ready handshake, and issues per-cycle OPMODE aligned to the slice pipeline.
- It captures the final P and returns it on a valid/ready result port.

Parameters:
- LEN_W, 16, width of job length field (max length 2^LEN_W-1).
- OPM_HOLD, 8'b00001000, OPMODE for a bubble: Z=P, X=0, so P holds.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  synchronous active-low reset.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs; sampled with start.
- acc_sub  in  1  0: P=ΣA·B; 1: P=−ΣA·B; sampled with start.
- op_valid  in  1  operand pair valid.
- op_a, op_b  in  18 each  unsigned operands.
- op_ready  out  1  operand pair accepted when op_valid&op_ready.
- result_valid  out  1  result available.
- result_ready  in  1  result consumed when result_valid&result_ready.
- result  out  48  accumulated dot product, modulo 2^48.
- busy  out  1  state != IDLE.
- dsp_a, dsp_b  out  18 each  to slice A and B.
- dsp_opmode  out  8  to slice OPMODE.
- dsp_ce  out  1  to slice CEA/CEB/CEM/CEP/CEOPMODE.
- dsp_rst  out  1  active-high; to slice RSTA/RSTB/RSTM/RSTP/RSTOPMODE.
- dsp_p  in  48  slice P output.

Behaviour:
- Reset (RST_N=0 at posedge):
  - state=IDLE, result=0, result_valid=0, op_ready=0, busy=0.
  - dsp_opmode=OPM_HOLD; all token-pipe stages cleared.
  - dsp_rst is a registered output: 1 during reset and for the first cycle after RST_N returns high, then 0.
  - dsp_ce=1 always except while dsp_rst=1.
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start=1 with len=0 → DONE, result=0 (no slice activity).
  - start=1 with len>0 → FEED; load cnt=len and latch acc_sub.
- FEED:
  - op_ready=1.
  - On accept: dsp_a=op_a, dsp_b=op_b, and a token enters stage s1 with flags first (first accepted pair of the job) and last (cnt==1); cnt decrements.
  - If op_valid=0: dsp_a=dsp_b=0 and a bubble token enters.
  - On accepting with cnt==1 → DRAIN.
- DRAIN: op_ready=0, bubbles enter. When the s3 token is valid and last: result<=dsp_p, result_valid<=1 → DONE.
- DONE: result_valid=1 and result held stable. On result_ready=1 → IDLE and result_valid<=0. start is ignored outside IDLE.
- Token pipe (s1, s2, s3 registered) tracks an operand accepted at cycle t:
  - s1 at t+1, when the slice A1/B1 registers hold it.
  - s2 at t+2, when the M register holds the product.
  - s3 at t+3, when P holds the sum.
- OPMODE alignment: dsp_opmode is combinational from s1, because the slice registers OPMODE once so it applies at t+2.
  - Valid first token: {acc_sub,0,0,0,2'b00,2'b01}, i.e. Z=0, X=M (P=±M).
  - Valid non-first token: {acc_sub,0,0,0,2'b10,2'b01}, i.e. Z=P, X=M.
  - Bubble/IDLE/DRAIN/DONE: OPM_HOLD.
  - OPMODE[6:4]=0 always: no pre-adder, CARRYIN=0.
- Latency: last pair accepted at cycle t → result_valid=1 from cycle t+4. Bubbles extend latency only by their count.
- Arithmetic: 18x18 unsigned products, 48-bit wrap, carry-out ignored. The subtract path computes P−M, so the first token gives 0−M.
- Reset mid-job: abort immediately; the slice is cleared via dsp_rst; no result is produced; a new job is accepted once back in IDLE.
- Back-to-back jobs: a new start is only possible after the result handshake, so no two jobs overlap in the slice.

Test Plan:
- len=3, acc_sub=0, pairs (2,3),(4,5),(6,7) streamed continuously → result=68 (0x44); result_valid rises exactly 4 cycles after the third accept.
- Same job with op_valid low for 2 cycles between pairs → result=68; latency from last accept still 4; P unchanged across bubbles.
- len=2, acc_sub=1, pairs (10,10),(3,3) → result=0xFFFF_FFFF_FF93 (−109 mod 2^48).
- len=0 → DONE on the next cycle with result=0; no OPMODE other than OPM_HOLD issued.
- len=2 with (0x3FFFF,0x3FFFF) twice, result_ready held low 5 cycles → result=0x1_FFFF_0000_2 (2·0xF_FFF8_0001) held stable until the handshake; start pulses during DONE are ignored.
- RST_N low for 1 cycle after the 2nd of 4 pairs → busy=0, result_valid=0, dsp_rst=1 for 2 cycles; a following len=1 job (5,5) → result=25.

Source files
------------

// File: rtl/dsp_dotprod_seq.sv
// Dot-product sequencer for a DSP48A1 slice used as a multiply-accumulate engine.
// Streams operand pairs into the slice, aligns OPMODE with the slice pipeline and captures the final P.
module dsp_dotprod_seq #(
   parameter int unsigned LEN_W    = 16,
   parameter logic [7:0]  OPM_HOLD = 8'b0000_1000
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              acc_sub,
   input  logic              op_valid,
   input  logic [17:0]       op_a,
   input  logic [17:0]       op_b,
   output logic              op_ready,
   output logic              result_valid,
   input  logic              result_ready,
   output logic [47:0]       result,
   output logic              busy,
   output logic [17:0]       dsp_a,
   output logic [17:0]       dsp_b,
   output logic [7:0]        dsp_opmode,
   output logic              dsp_ce,
   output logic              dsp_rst,
   input  logic [47:0]       dsp_p
);

   localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FEED  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_accept;
   logic [LEN_W-1:0]  r_cnt;
   logic              r_sub;
   logic              r_first;
   logic              r_s1_v, r_s1_first, r_s1_last;
   logic              r_s2_v, r_s2_last;
   logic              r_s3_v, r_s3_last;
   logic [47:0]       r_result;
   logic              r_result_valid;
   logic              r_dsp_rst;
   logic              r_rst_hold;

   // State register
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode, operand steering and OPMODE selection
   always_comb begin
      w_state_nxt = r_state;
      op_ready    = 1'b0;
      w_accept    = 1'b0;
      dsp_a       = 18'd0;
      dsp_b       = 18'd0;
      busy        = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (len == CNT_ZERO) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_FEED;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_FEED: begin
            op_ready = 1'b1;
            if (op_valid) begin
               w_accept = 1'b1;
               dsp_a    = op_a;
               dsp_b    = op_b;
               if (r_cnt == CNT_ONE) begin
                  w_state_nxt = S_DRAIN;
               end else begin
                  w_state_nxt = S_FEED;
               end
            end else begin
               w_state_nxt = S_FEED;
            end
         end
         S_DRAIN: begin
            if (r_s3_v && r_s3_last) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DONE: begin
            if (result_ready) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      // The slice registers OPMODE once, so an s1 token's mode meets its product in M.
      if (r_s1_v) begin
         dsp_opmode = {r_sub, 3'b000, (r_s1_first ? 2'b00 : 2'b10), 2'b01};
      end else begin
         dsp_opmode = OPM_HOLD;
      end
   end

   // Job bookkeeping, token pipe, result capture and slice reset stretch
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_cnt          <= CNT_ZERO;
         r_sub          <= 1'b0;
         r_first        <= 1'b0;
         r_s1_v         <= 1'b0;
         r_s1_first     <= 1'b0;
         r_s1_last      <= 1'b0;
         r_s2_v         <= 1'b0;
         r_s2_last      <= 1'b0;
         r_s3_v         <= 1'b0;
         r_s3_last      <= 1'b0;
         r_result       <= 48'd0;
         r_result_valid <= 1'b0;
         r_dsp_rst      <= 1'b1;
         r_rst_hold     <= 1'b1;
      end else begin
         r_dsp_rst  <= r_rst_hold;
         r_rst_hold <= 1'b0;
         r_s1_v     <= w_accept;
         r_s1_first <= w_accept & r_first;
         r_s1_last  <= w_accept & (r_cnt == CNT_ONE);
         r_s2_v     <= r_s1_v;
         r_s2_last  <= r_s1_last;
         r_s3_v     <= r_s2_v;
         r_s3_last  <= r_s2_last;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cnt   <= len;
                  r_sub   <= acc_sub;
                  r_first <= 1'b1;
                  if (len == CNT_ZERO) begin
                     r_result       <= 48'd0;
                     r_result_valid <= 1'b1;
                  end
               end
            end
            S_FEED: begin
               if (w_accept) begin
                  r_cnt   <= r_cnt - CNT_ONE;
                  r_first <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (r_s3_v && r_s3_last) begin
                  r_result       <= dsp_p;
                  r_result_valid <= 1'b1;
               end
            end
            S_DONE: begin
               if (result_ready) begin
                  r_result_valid <= 1'b0;
               end
            end
            default: begin
               r_result_valid <= 1'b0;
            end
         endcase
      end
   end

   assign result       = r_result;
   assign result_valid = r_result_valid;
   assign dsp_rst      = r_dsp_rst;
   assign dsp_ce       = ~r_dsp_rst;

endmodule

// File: tb/tb_dsp_dotprod_seq.sv
// Bench for dsp_dotprod_seq: a behavioural DSP48A1 slice closes the loop, and a plain-arithmetic
// dot-product model supplies every expected result, latency and OPMODE value.
module tb_dsp_dotprod_seq;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        start = 1'b0;
   logic [15:0] len = 16'd0;
   logic        acc_sub = 1'b0;
   logic        op_valid = 1'b0;
   logic [17:0] op_a = 18'd0;
   logic [17:0] op_b = 18'd0;
   logic        op_ready;
   logic        result_valid;
   logic        result_ready = 1'b0;
   logic [47:0] result;
   logic        busy;
   logic [17:0] dsp_a, dsp_b;
   logic [7:0]  dsp_opmode;
   logic        dsp_ce, dsp_rst;
   logic [47:0] dsp_p;

   int ncmp = 0;
   int nfail = 0;
   int cyc = 0;
   logic [17:0] qa [0:15];
   logic [17:0] qb [0:15];

   dsp_dotprod_seq #(.LEN_W(16), .OPM_HOLD(8'b0000_1000)) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .len(len), .acc_sub(acc_sub),
      .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
      .result_valid(result_valid), .result_ready(result_ready), .result(result),
      .busy(busy), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
      .dsp_ce(dsp_ce), .dsp_rst(dsp_rst), .dsp_p(dsp_p)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Behavioural slice: A1/B1 -> M -> P, OPMODE registered once.
   logic [17:0] m_a1, m_b1;
   logic [35:0] m_m;
   logic [7:0]  m_opm;
   logic [47:0] m_p, m_x, m_z;
   always_comb begin
      m_x = (m_opm[1:0] == 2'b01) ? {12'd0, m_m} : 48'd0;
      m_z = (m_opm[3:2] == 2'b10) ? m_p : 48'd0;
   end
   always @(posedge CLK) begin
      if (dsp_rst) begin
         m_a1 <= 18'd0; m_b1 <= 18'd0; m_m <= 36'd0; m_opm <= 8'd0; m_p <= 48'd0;
      end else if (dsp_ce) begin
         m_a1  <= dsp_a;
         m_b1  <= dsp_b;
         m_m   <= {18'd0, m_a1} * {18'd0, m_b1};
         m_opm <= dsp_opmode;
         m_p   <= m_opm[7] ? (m_z - m_x) : (m_z + m_x);
      end
   end
   assign dsp_p = m_p;

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [47:0] exp_opm(input bit acc, input bit first, input bit sub);
      if (!acc) return 48'h08;
      return 48'({sub, 3'b000, (first ? 2'b00 : 2'b10), 2'b01});
   endfunction

   task automatic do_job(input int n, input bit sub, input int bub_pct, input int rdy_dly,
                         input bit poke_start);
      logic [47:0] exp_v;
      int i, guard, acc_cyc;
      bit prev_acc, prev_first;
      exp_v = 48'd0;
      for (int k = 0; k < n; k++) exp_v = exp_v + {30'd0, qa[k]} * {30'd0, qb[k]};
      if (sub) exp_v = 48'd0 - exp_v;
      @(negedge CLK);
      start = 1'b1; len = 16'(n); acc_sub = sub;
      @(negedge CLK);
      start = 1'b0; len = 16'd0; acc_sub = 1'b0;
      check("busy_start", 48'(busy), 48'd1);
      if (n == 0) begin
         check("len0_valid", 48'(result_valid), 48'd1);
         check("len0_opmode", 48'(dsp_opmode), 48'h08);
      end else begin
         i = 0; guard = 0; acc_cyc = 0; prev_acc = 1'b0; prev_first = 1'b0;
         while (i < n && guard < 2000) begin
            check("feed_opmode", 48'(dsp_opmode), exp_opm(prev_acc, prev_first, sub));
            check("feed_ready", 48'(op_ready), 48'd1);
            if (int'($urandom_range(99)) < bub_pct) begin
               op_valid = 1'b0; op_a = 18'($urandom); op_b = 18'($urandom);
               #1 check("bubble_a", 48'(dsp_a), 48'd0);
               prev_acc = 1'b0;
            end else begin
               op_valid = 1'b1; op_a = qa[i]; op_b = qb[i];
               #1 check("accept_a", 48'(dsp_a), 48'(qa[i]));
               prev_acc = 1'b1; prev_first = (i == 0); acc_cyc = cyc; i++;
            end
            @(negedge CLK);
            guard++;
         end
         op_valid = 1'b0; op_a = 18'd0; op_b = 18'd0;
         guard = 0;
         while (!result_valid && guard < 20) begin
            check("drain_opmode", 48'(dsp_opmode), exp_opm(prev_acc, prev_first, sub));
            check("drain_ready", 48'(op_ready), 48'd0);
            prev_acc = 1'b0;
            @(negedge CLK);
            guard++;
         end
         check("latency", 48'(cyc - acc_cyc), 48'd4);
      end
      check("result", result, exp_v);
      for (int k = 0; k < rdy_dly; k++) begin
         if (poke_start) begin start = 1'b1; len = 16'd1; end
         @(negedge CLK);
         start = 1'b0; len = 16'd0;
         check("hold_valid", 48'(result_valid), 48'd1);
         check("hold_result", result, exp_v);
         check("hold_opmode", 48'(dsp_opmode), 48'h08);
      end
      result_ready = 1'b1;
      @(negedge CLK);
      result_ready = 1'b0;
      check("post_valid", 48'(result_valid), 48'd0);
      check("post_busy", 48'(busy), 48'd0);
   endtask

   initial begin
      // Power-on reset
      RST_N = 1'b0;
      repeat (2) @(negedge CLK);
      check("rst_result", result, 48'd0);
      check("rst_valid", 48'(result_valid), 48'd0);
      check("rst_ready", 48'(op_ready), 48'd0);
      check("rst_busy", 48'(busy), 48'd0);
      check("rst_opmode", 48'(dsp_opmode), 48'h08);
      check("rst_dsprst", 48'(dsp_rst), 48'd1);
      check("rst_ce", 48'(dsp_ce), 48'd0);
      RST_N = 1'b1;
      @(negedge CLK);
      check("rst_stretch", 48'(dsp_rst), 48'd1);
      @(negedge CLK);
      check("rst_release", 48'(dsp_rst), 48'd0);
      check("ce_on", 48'(dsp_ce), 48'd1);

      // Continuous len=3 sum: 68
      qa[0] = 18'd2; qb[0] = 18'd3; qa[1] = 18'd4; qb[1] = 18'd5; qa[2] = 18'd6; qb[2] = 18'd7;
      do_job(3, 1'b0, 0, 0, 1'b0);
      // Same job with bubbles
      do_job(3, 1'b0, 50, 1, 1'b0);
      // Subtract path: -109
      qa[0] = 18'd10; qb[0] = 18'd10; qa[1] = 18'd3; qb[1] = 18'd3;
      do_job(2, 1'b1, 0, 0, 1'b0);
      // Empty job
      do_job(0, 1'b0, 0, 1, 1'b0);
      // Maximal operands, slow consumer, ignored start pulses in DONE
      qa[0] = 18'h3FFFF; qb[0] = 18'h3FFFF; qa[1] = 18'h3FFFF; qb[1] = 18'h3FFFF;
      do_job(2, 1'b0, 0, 5, 1'b1);

      // Reset after the 2nd of 4 pairs
      qa[0] = 18'd1; qb[0] = 18'd2; qa[1] = 18'd3; qb[1] = 18'd4;
      @(negedge CLK);
      start = 1'b1; len = 16'd4;
      @(negedge CLK);
      start = 1'b0; len = 16'd0;
      for (int k = 0; k < 2; k++) begin
         op_valid = 1'b1; op_a = qa[k]; op_b = qb[k];
         @(negedge CLK);
      end
      op_valid = 1'b0; RST_N = 1'b0;
      @(negedge CLK);
      check("abort_busy", 48'(busy), 48'd0);
      check("abort_valid", 48'(result_valid), 48'd0);
      check("abort_dsprst", 48'(dsp_rst), 48'd1);
      check("abort_opmode", 48'(dsp_opmode), 48'h08);
      RST_N = 1'b1;
      @(negedge CLK);
      check("abort_dsprst2", 48'(dsp_rst), 48'd1);
      check("abort_busy2", 48'(busy), 48'd0);
      @(negedge CLK);
      check("abort_dsprst3", 48'(dsp_rst), 48'd0);
      qa[0] = 18'd5; qb[0] = 18'd5;
      do_job(1, 1'b0, 0, 0, 1'b0);

      // Randomized jobs
      for (int j = 0; j < 12; j++) begin
         int n;
         n = int'($urandom_range(1, 12));
         for (int k = 0; k < n; k++) begin
            qa[k] = 18'($urandom);
            qb[k] = 18'($urandom);
         end
         do_job(n, 1'($urandom), 30, int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
